// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart_tx serializer among N_REQ byte producers.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, pointer held at 0).
module uart_tx_arb #(
  parameter int N_REQ     = 4,
  parameter int BUSY_WAIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [2:0]         grant_id,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               busy,
  output logic               err,
  output logic [1:0]         dbg_state,
  output logic [2:0]         dbg_ptr
);

  localparam int CW = $clog2(BUSY_WAIT + 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [2:0]         grant_q, grant_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               win_vld;
  logic [2:0]         win_id;
  logic [7:0]         win_data;
  logic [N_REQ-1:0]   win_onehot;
  logic [2:0]         scan_base;
  logic [2:0]         next_ptr;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign scan_base = 3'd0;
  assign next_ptr  = 3'd0;
`else
  assign scan_base = ptr_q;
  assign next_ptr  = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
`endif

  // First pass finds a request at or above the pointer; second pass wraps to the bottom.
  always_comb begin : rr_pick
    win_vld    = 1'b0;
    win_id     = 3'd0;
    win_data   = 8'h00;
    win_onehot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!win_vld && req[j] && (3'(j) >= scan_base)) begin
        win_vld = 1'b1;
        win_id  = 3'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!win_vld && req[j]) begin
        win_vld = 1'b1;
        win_id  = 3'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (3'(j) == win_id) begin
        win_data      = req_data[j*8 +: 8];
        win_onehot[j] = win_vld;
      end
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    ack_d      = '0;
    grant_d    = grant_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    err_d      = 1'b0;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        // An externally started frame keeps the serializer busy; hold off arbitration.
        if (win_vld && !tx_busy) begin
          ack_d     = win_onehot;
          grant_d   = win_id;
          tx_data_d = win_data;
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q == CW'(BUSY_WAIT)) begin
          // Frame lost: still rotate so a broken client cannot starve the rest.
          err_d   = 1'b1;
          ptr_d   = next_ptr;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          ptr_d   = next_ptr;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ack_q      <= '0;
      grant_q    <= 3'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ptr_q      <= 3'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ack       = ack_q;
  assign grant_id  = grant_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule
